// File: rtl/bus_pkg.sv
// Shared types and frame-slot cycle constants for the 6502/RAM bus sequencer.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MCU_XFER,
    CPU
  } state_t;

  localparam int unsigned BASE_FRAME        = 64;
  localparam int unsigned MCU_ADDR_START    = 1;
  localparam int unsigned MCU_ADDR_END      = 30;
  localparam int unsigned MCU_DATA_START    = 2;
  localparam int unsigned MCU_DATA_END      = 29;
  localparam int unsigned MCU_STROBE_START  = 4;
  localparam int unsigned MCU_STROBE_END    = 27;
  localparam int unsigned MCU_RD_STROBE_END = 28;
  localparam int unsigned MCU_CAPTURE       = 27;
  localparam int unsigned MCU_ACK           = 28;
  localparam int unsigned CPU_BE_START      = 32;
  localparam int unsigned CPU_PHI2_START    = 48;
  localparam int unsigned CPU_VALID_START   = 44;
  localparam int unsigned CPU_VALID_END     = 61;

  function automatic logic in_win(input int unsigned n, input int unsigned lo,
                                  input int unsigned hi);
    return (n >= lo) && (n <= hi);
  endfunction

endpackage

// File: rtl/bus_frame_timer.sv
// Free-running frame counter with registered window strobes.
// Every strobe is one cycle early: high in cycle c when cycle c+1 lies in its window.
module bus_frame_timer
  import bus_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_frame_end,
  output logic o_slot_end,
  output logic o_addr_win,
  output logic o_data_win,
  output logic o_wr_win,
  output logic o_rd_win,
  output logic o_cap_win,
  output logic o_ack_win,
  output logic o_be_win,
  output logic o_phi2_win,
  output logic o_valid_win
);

  localparam int unsigned CW  = $clog2(FRAME_CYCLES);
  localparam int unsigned EXT = FRAME_CYCLES - BASE_FRAME;

  logic [CW-1:0] r_fc;
  logic [CW-1:0] w_fc_la;
  logic [31:0]   w_n;

  // Decode two ahead so the registered strobe lines up with the following cycle.
  assign w_fc_la = r_fc + CW'(2);
  assign w_n     = 32'(w_fc_la);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fc        <= '0;
      o_frame_end <= 1'b0;
      o_slot_end  <= 1'b0;
      o_addr_win  <= 1'b0;
      o_data_win  <= 1'b0;
      o_wr_win    <= 1'b0;
      o_rd_win    <= 1'b0;
      o_cap_win   <= 1'b0;
      o_ack_win   <= 1'b0;
      o_be_win    <= 1'b0;
      o_phi2_win  <= 1'b0;
      o_valid_win <= 1'b0;
    end else begin
      r_fc        <= r_fc + CW'(1);
      o_frame_end <= (w_n == 32'd0);
      o_slot_end  <= (w_n == CPU_BE_START);
      o_addr_win  <= in_win(w_n, MCU_ADDR_START, MCU_ADDR_END);
      o_data_win  <= in_win(w_n, MCU_DATA_START, MCU_DATA_END);
      o_wr_win    <= in_win(w_n, MCU_STROBE_START, MCU_STROBE_END);
      o_rd_win    <= in_win(w_n, MCU_STROBE_START, MCU_RD_STROBE_END);
      o_cap_win   <= in_win(w_n, MCU_CAPTURE + 1, MCU_CAPTURE + 1);
      o_ack_win   <= in_win(w_n, MCU_ACK, MCU_ACK);
      o_be_win    <= in_win(w_n, CPU_BE_START, FRAME_CYCLES - 1);
      o_phi2_win  <= in_win(w_n, CPU_PHI2_START + EXT, FRAME_CYCLES - 1);
      o_valid_win <= in_win(w_n, CPU_VALID_START + EXT, CPU_VALID_END + EXT);
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Time-division sequencer: one Wishbone-to-RAM transfer in the MCU half of each
// frame, 6502 bus ownership (BE/PHI2) in the CPU half.
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned WB_ADDR_WIDTH  = 20,
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned FRAME_CYCLES   = 64
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  input  logic                      wb_we_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  output logic                      wb_stall_o,
  output logic                      wb_ack_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic                      ram_oe_o,
  output logic                      ram_we_o,
  output logic                      cpu_addr_oe,
  input  logic [DATA_WIDTH-1:0]     cpu_data_i,
  output logic [DATA_WIDTH-1:0]     cpu_data_o,
  output logic                      cpu_data_oe,
  output logic                      cpu_be_o,
  output logic                      cpu_clk_o,
  output logic                      cpu_valid_o
);

  logic w_frame_end, w_slot_end, w_addr_win, w_data_win, w_wr_win, w_rd_win;
  logic w_cap_win, w_ack_win, w_be_win, w_phi2_win, w_valid_win;

  bus_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .i_clk      (clock_i),
    .i_rst_n    (reset_ni),
    .o_frame_end(w_frame_end),
    .o_slot_end (w_slot_end),
    .o_addr_win (w_addr_win),
    .o_data_win (w_data_win),
    .o_wr_win   (w_wr_win),
    .o_rd_win   (w_rd_win),
    .o_cap_win  (w_cap_win),
    .o_ack_win  (w_ack_win),
    .o_be_win   (w_be_win),
    .o_phi2_win (w_phi2_win),
    .o_valid_win(w_valid_win)
  );

  state_t r_state, w_state_next;

  logic                      r_pending;
  logic [RAM_ADDR_WIDTH-1:0] r_req_addr;
  logic                      r_req_ok;
  logic                      r_req_we;
  logic [DATA_WIDTH-1:0]     r_req_data;

  logic [RAM_ADDR_WIDTH-1:0] r_x_addr;
  logic                      r_x_ok;
  logic                      r_x_we;
  logic [DATA_WIDTH-1:0]     r_x_data;

  logic w_accept, w_in_range, w_start, w_mcu, w_cpu;
  logic w_addr_oe, w_data_oe, w_ram_we, w_ram_oe, w_ack, w_capture;

  assign wb_stall_o = r_pending;
  assign w_accept   = wb_cyc_i & wb_stb_i & ~r_pending;
  assign w_in_range = ((wb_addr_i >> RAM_ADDR_WIDTH) == '0);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, MCU_XFER: if (w_slot_end) w_state_next = CPU;
      CPU:            if (w_frame_end) w_state_next = (r_pending || w_accept) ? MCU_XFER : IDLE;
      default:        w_state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so all windows use the look-ahead strobes.
  always_comb begin
    w_start   = (w_state_next == MCU_XFER) && (r_state != MCU_XFER);
    w_mcu     = (w_state_next == MCU_XFER);
    w_cpu     = (w_state_next == CPU);
    w_addr_oe = w_mcu & w_addr_win & r_x_ok;
    w_data_oe = w_mcu & w_data_win & r_x_ok & r_x_we;
    w_ram_we  = w_mcu & w_wr_win & r_x_ok & r_x_we;
    w_ram_oe  = w_mcu & w_rd_win & r_x_ok & ~r_x_we;
    w_ack     = w_mcu & w_ack_win;
    w_capture = w_mcu & w_cap_win & ~r_x_we;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_pending  <= 1'b0;
      r_req_addr <= '0;
      r_req_ok   <= 1'b0;
      r_req_we   <= 1'b0;
      r_req_data <= '0;
    end else if (w_ack) begin
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_pending  <= 1'b1;
      r_req_addr <= wb_addr_i[RAM_ADDR_WIDTH-1:0];
      r_req_ok   <= w_in_range;
      r_req_we   <= wb_we_i;
      r_req_data <= wb_data_i;
    end
  end

  // Transfer copy keeps the slot stable when a new request is accepted after the ack.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_x_addr <= '0;
      r_x_ok   <= 1'b0;
      r_x_we   <= 1'b0;
      r_x_data <= '0;
    end else if (w_start) begin
      r_x_addr <= w_accept ? wb_addr_i[RAM_ADDR_WIDTH-1:0] : r_req_addr;
      r_x_ok   <= w_accept ? w_in_range : r_req_ok;
      r_x_we   <= w_accept ? wb_we_i : r_req_we;
      r_x_data <= w_accept ? wb_data_i : r_req_data;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ram_addr_o  <= '0;
      ram_oe_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      cpu_addr_oe <= 1'b0;
      cpu_data_o  <= '0;
      cpu_data_oe <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_data_o   <= '0;
      cpu_be_o    <= 1'b0;
      cpu_clk_o   <= 1'b0;
      cpu_valid_o <= 1'b0;
    end else begin
      ram_addr_o  <= w_addr_oe ? r_x_addr : '0;
      ram_oe_o    <= w_ram_oe;
      ram_we_o    <= w_ram_we;
      cpu_addr_oe <= w_addr_oe;
      cpu_data_o  <= w_data_oe ? r_x_data : '0;
      cpu_data_oe <= w_data_oe;
      wb_ack_o    <= w_ack;
      if (w_capture) wb_data_o <= r_x_ok ? cpu_data_i : '0;
      cpu_be_o    <= w_cpu & w_be_win;
      cpu_clk_o   <= w_cpu & w_phi2_win;
      cpu_valid_o <= w_cpu & w_valid_win;
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed, table-driven bench for bus_sequencer with a cycle-window reference model.
`timescale 1ns/1ps
module tb_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] wb_addr_i = '0;
  logic [7:0]  wb_data_i = '0;
  logic [7:0]  wb_data_o;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic        wb_stall_o, wb_ack_o;
  logic [16:0] ram_addr_o;
  logic        ram_oe_o, ram_we_o, cpu_addr_oe;
  logic [7:0]  cpu_data_i, cpu_data_o;
  logic        cpu_data_oe, cpu_be_o, cpu_clk_o, cpu_valid_o;

  logic [16:0] m_addr = '0;
  logic [7:0]  m_val = '0;
  assign cpu_data_i = (ram_oe_o && ram_addr_o == m_addr) ? m_val : 8'hFF;

  always #8 clk = ~clk;

  bus_sequencer #(
    .DATA_WIDTH(8), .WB_ADDR_WIDTH(20), .RAM_ADDR_WIDTH(17), .FRAME_CYCLES(64)
  ) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_data_o(wb_data_o),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_stall_o(wb_stall_o), .wb_ack_o(wb_ack_o),
    .ram_addr_o(ram_addr_o), .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o),
    .cpu_addr_oe(cpu_addr_oe), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_data_oe(cpu_data_oe), .cpu_be_o(cpu_be_o), .cpu_clk_o(cpu_clk_o),
    .cpu_valid_o(cpu_valid_o)
  );

  logic [5:0] fc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) fc <= '0;
    else        fc <= fc + 6'd1;

  typedef struct {
    int unsigned afc;
    logic        we;
    logic [19:0] addr;
    logic [7:0]  data;
    logic [7:0]  rval;
    logic        ok;
    logic [16:0] raddr;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[6];
  vec_t dummy;
  int   total = 0;
  int   bad = 0;
  logic [7:0] last_rd = '0;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s fc=%0d got=%h want=%h", nm, fc, got, want);
    end
  endtask

  task automatic check_cycle(input string nm, input logic active, input vec_t v,
                             input logic stall_exp);
    logic a;
    logic e_aoe, e_doe, e_we, e_oe, e_ack, e_be, e_clk, e_val;
    logic [33:0] exp_v, got_v;
    a     = active & v.ok;
    e_aoe = a & (fc >= 1 && fc <= 30);
    e_doe = a & v.we & (fc >= 2 && fc <= 29);
    e_we  = a & v.we & (fc >= 4 && fc <= 27);
    e_oe  = a & ~v.we & (fc >= 4 && fc <= 28);
    e_ack = active & (fc == 28);
    e_be  = (fc >= 32);
    e_clk = (fc >= 48);
    e_val = (fc >= 44 && fc <= 61);
    exp_v = {e_aoe, e_doe, e_we, e_oe, e_ack, e_be, e_clk, e_val, stall_exp,
             e_aoe ? v.raddr : 17'h0, e_doe ? v.data : 8'h00};
    got_v = {cpu_addr_oe, cpu_data_oe, ram_we_o, ram_oe_o, wb_ack_o, cpu_be_o,
             cpu_clk_o, cpu_valid_o, wb_stall_o, ram_addr_o, cpu_data_o};
    cmp(nm, 64'(got_v), 64'(exp_v));
  endtask

  task automatic wait_fc(input int unsigned target, input logic chk);
    int g;
    g = 0;
    while (fc != target[5:0] && g < 200) begin
      if (chk) check_cycle("idle", 1'b0, dummy, 1'b0);
      @(negedge clk);
      g++;
    end
    cmp("wait_fc_timeout", 64'(fc), 64'(target));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int g;
    wait_fc(v.afc, 1'b1);
    check_cycle({nm, "_pre"}, 1'b0, dummy, 1'b0);
    m_addr = v.raddr; m_val = v.rval;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
    wb_addr_i = v.addr; wb_data_i = v.data;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    g = 0;
    while (fc != 6'd0 && g < 64) begin
      check_cycle({nm, "_wait"}, 1'b0, dummy, 1'b1);
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 64; i++) begin
      check_cycle(nm, fc < 32, v, fc < 28);
      if (fc == 6'd28) begin
        cmp({nm, "_rdata"}, 64'(wb_data_o), 64'(v.we ? last_rd : v.rdata));
        if (!v.we) last_rd = v.rdata;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int be_rise[2];
    int clk_rise;
    int nb;
    int n;
    logic prev_be, prev_clk;

    dummy    = '{0, 1'b0, 20'h0, 8'h0, 8'h0, 1'b0, 17'h0, 8'h0};
    vecs[0]  = '{10, 1'b1, 20'h01234, 8'hA5, 8'h00, 1'b1, 17'h01234, 8'h00};
    vecs[1]  = '{10, 1'b0, 20'h1FFFF, 8'h00, 8'h3C, 1'b1, 17'h1FFFF, 8'h3C};
    vecs[2]  = '{63, 1'b0, 20'h00055, 8'h00, 8'h77, 1'b1, 17'h00055, 8'h77};
    vecs[3]  = '{40, 1'b0, 20'h20000, 8'h00, 8'h99, 1'b0, 17'h00000, 8'h00};
    vecs[4]  = '{5,  1'b1, 20'h3FFFF, 8'h11, 8'h00, 1'b0, 17'h1FFFF, 8'h00};
    vecs[5]  = '{31, 1'b1, 20'h1ABCD, 8'h5A, 8'h00, 1'b1, 17'h1ABCD, 8'h00};

    // Reset: every output low while held.
    repeat (10) @(negedge clk);
    cmp("reset_outputs", 64'({wb_data_o, wb_stall_o, wb_ack_o, ram_addr_o, ram_oe_o, ram_we_o,
                              cpu_addr_oe, cpu_data_o, cpu_data_oe, cpu_be_o, cpu_clk_o,
                              cpu_valid_o}), 64'd0);
    rst_n = 1'b1;

    be_rise = '{-1, -1}; clk_rise = -1; nb = 0;
    prev_be = 1'b0; prev_clk = 1'b0;
    for (int i = 0; i < 130; i++) begin
      check_cycle("free_run", 1'b0, dummy, 1'b0);
      if (cpu_be_o && !prev_be && nb < 2) begin be_rise[nb] = i; nb++; end
      if (cpu_clk_o && !prev_clk && clk_rise < 0) clk_rise = i;
      prev_be = cpu_be_o; prev_clk = cpu_clk_o;
      @(negedge clk);
    end
    cmp("be_first_rise", 64'(be_rise[0]), 64'd32);
    cmp("phi2_first_rise", 64'(clk_rise), 64'd48);
    cmp("be_period", 64'(be_rise[1] - be_rise[0]), 64'd64);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Accept just after the frame boundary waits a whole frame.
    wait_fc(0, 1'b1);
    m_addr = 17'h00055; m_val = 8'h77;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 20'h00055;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    n = 1;
    while (!wb_ack_o && n < 200) begin @(negedge clk); n++; end
    cmp("latency_fc0", 64'(n), 64'd92);
    cmp("latency_rdata", 64'(wb_data_o), 64'h77);
    last_rd = 8'h77;
    wait_fc(0, 1'b0);

    // Abort a write mid-slot with reset.
    wait_fc(10, 1'b1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_addr_i = 20'h00100; wb_data_i = 8'hC3;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wait_fc(0, 1'b0);
    wait_fc(15, 1'b0);
    cmp("abort_before", 64'({ram_we_o, cpu_data_oe, wb_stall_o}), 64'h7);
    #2 rst_n = 1'b0;
    #1 cmp("abort_async", 64'({ram_we_o, cpu_data_oe, wb_stall_o, wb_ack_o}), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_rd = 8'h00;
    for (int i = 0; i < 64; i++) begin
      check_cycle("post_abort", 1'b0, dummy, 1'b0);
      @(negedge clk);
    end
    run_vec(vecs[0], "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
